pipe_reg_skid: RTL and testbench

PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

---
 rtl/pipe_reg_skid.sv | 126 ++++++++++++
 tb/tb_pipe_reg_skid.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_skid.sv
// Two-entry skid-buffered pipeline register with a registered in_ready.
// Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_reg_skid #(
  parameter int unsigned D_BITS      = 32,
  parameter int unsigned OP_BITS     = 7,
  parameter int unsigned DEST_BITS   = 3,
  parameter int unsigned NUM_OPS     = 2,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_sgn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OP_BITS-1:0]          in_opcode,
  input  logic [DEST_BITS-1:0]        in_dest,
  input  logic [NUM_OPS*D_BITS-1:0]   in_ops,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OP_BITS-1:0]          out_opcode,
  output logic [DEST_BITS-1:0]        out_dest,
  output logic [NUM_OPS*D_BITS-1:0]   out_ops
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]      stall_cnt
`endif
);

  localparam int unsigned ENT_W = OP_BITS + DEST_BITS + NUM_OPS * D_BITS;

  if (NUM_OPS < 1 || NUM_OPS > 4 || STALL_CNT_W < 1) begin : g_param_check
    $error("pipe_reg_skid: NUM_OPS must be 1..4 and STALL_CNT_W at least 1");
  end

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [ENT_W-1:0]   main_q, main_d;
  logic [ENT_W-1:0]   skid_q, skid_d;
  logic [ENT_W-1:0]   in_ent;
  logic               xfer_in, xfer_out;

  assign in_ent = {in_opcode, in_dest, in_ops};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  // in_ready is the registered image of the next state, so out_ready never
  // reaches it combinationally.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    xfer_in  = in_valid && in_ready_q;
    xfer_out = (state_q != EMPTY) && out_ready;
    unique case (state_q)
      EMPTY: begin
        if (xfer_in) begin
          main_d  = in_ent;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer_in && xfer_out) begin
          main_d = in_ent;
        end else if (xfer_in) begin
          skid_d  = in_ent;
          state_d = FULL;
        end else if (xfer_out) begin
          main_d  = '0;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer_out) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (clr_sgn) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
    in_ready_d = (state_d != FULL);
  end

  always_comb begin
    out_valid                         = (state_q != EMPTY);
    in_ready                          = in_ready_q;
    {out_opcode, out_dest, out_ops}   = main_q;
  end

`ifdef PIPE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != EMPTY) && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed self-checking bench for pipe_reg_skid: default instance plus a
// NUM_OPS=3 / D_BITS=16 instance; counter checks run when PIPE_STALL_CNT_EN is set.
module tb_pipe_reg_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_sgn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_dest = '0;
  logic [63:0] in_ops = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  out_opcode;
  logic [2:0]  out_dest;
  logic [63:0] out_ops;
  logic [3:0]  stall_cnt;

  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [6:0]  in_opcode3 = '0;
  logic [2:0]  in_dest3 = '0;
  logic [47:0] in_ops3 = '0;
  logic        out_valid3;
  logic        out_ready3 = 1'b0;
  logic [6:0]  out_opcode3;
  logic [2:0]  out_dest3;
  logic [47:0] out_ops3;
  logic [3:0]  stall_cnt3;

  int vecs = 0;
  int errs = 0;
  logic [75:0] got, exp;

  always #5 clk = ~clk;

  pipe_reg_skid #(.STALL_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .clr_sgn(clr_sgn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_dest(in_dest), .in_ops(in_ops),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_dest(out_dest), .out_ops(out_ops)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  pipe_reg_skid #(.D_BITS(16), .NUM_OPS(3), .STALL_CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .clr_sgn(1'b0),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .in_opcode(in_opcode3), .in_dest(in_dest3), .in_ops(in_ops3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_opcode(out_opcode3), .out_dest(out_dest3), .out_ops(out_ops3)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt3)
`endif
  );

`ifndef PIPE_STALL_CNT_EN
  assign stall_cnt  = '0;
  assign stall_cnt3 = '0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] d,
                       input logic [63:0] ops);
    in_valid  = v;
    in_opcode = op;
    in_dest   = d;
    in_ops    = ops;
  endtask

  task automatic test_reset();
    tick();
    tick();
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    exp = '0;
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL reset_held: got %h expected %h", got, exp);
    end
    rst = 1'b0;
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_release_pre_edge in_ready: got %b expected 0", in_ready);
    end
    tick();
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    exp = {1'b0, 1'b1, 74'd0};
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL reset_first_edge: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 7'h13, 3'(i), {32'(2 * i), 32'(i)});
      tick();
      got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
      exp = {1'b1, 1'b1, 7'h13, 3'(i), 32'(2 * i), 32'(i)};
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL stream_%0d: got %h expected %h", i, got, exp);
      end
    end
    drive(1'b0, '0, '0, '0);
    tick();
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    exp = {1'b0, 1'b1, 74'd0};
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL stream_drain_nop: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_backpressure();
    logic [73:0] a, b, c;
    a = {7'h0A, 3'd1, 32'hA1, 32'hA0};
    b = {7'h0B, 3'd2, 32'hB1, 32'hB0};
    c = {7'h0C, 3'd3, 32'hC1, 32'hC0};
    out_ready = 1'b0;
    drive(1'b1, a[73:67], a[66:64], a[63:0]);
    tick();
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    exp = {1'b1, 1'b1, a};
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL bp_push_a: got %h expected %h", got, exp);
    end
    drive(1'b1, b[73:67], b[66:64], b[63:0]);
    tick();
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    exp = {1'b1, 1'b0, a};
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL bp_full: got %h expected %h", got, exp);
    end
    drive(1'b1, c[73:67], c[66:64], c[63:0]);
    for (int k = 0; k < 2; k++) begin
      tick();
      got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
      exp = {1'b1, 1'b0, a};
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL bp_hold_%0d: got %h expected %h", k, got, exp);
      end
    end
    out_ready = 1'b1;
    tick();
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    exp = {1'b1, 1'b1, b};
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL bp_release_b: got %h expected %h", got, exp);
    end
    tick();
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    exp = {1'b1, 1'b1, c};
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL bp_release_c: got %h expected %h", got, exp);
    end
    drive(1'b0, '0, '0, '0);
    tick();
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    exp = {1'b0, 1'b1, 74'd0};
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL bp_drained: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 7'h21, 3'd1, 64'h1);
    tick();
    drive(1'b1, 7'h22, 3'd2, 64'h2);
    tick();
    drive(1'b1, 7'h23, 3'd3, 64'h3);
    clr_sgn = 1'b1;
    tick();
    clr_sgn = 1'b0;
    drive(1'b0, '0, '0, '0);
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    exp = {1'b0, 1'b1, 74'd0};
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL flush_full: got %h expected %h", got, exp);
    end
    out_ready = 1'b1;
    tick();
    tick();
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL flush_no_emerge: got %h expected %h", got, exp);
    end
    out_ready = 1'b0;
    drive(1'b1, 7'h24, 3'd4, 64'h4);
    tick();
    drive(1'b1, 7'h25, 3'd5, 64'h5);
    clr_sgn = 1'b1;
    tick();
    clr_sgn = 1'b0;
    drive(1'b0, '0, '0, '0);
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL flush_busy_discard_in: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 7'h31, 3'd6, 64'h0000_0031_0000_0030);
    tick();
    drive(1'b0, '0, '0, '0);
    #3;
    rst = 1'b1;
    #1;
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    exp = '0;
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL async_reset_immediate: got %h expected %h", got, exp);
    end
    tick();
    rst = 1'b0;
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL async_release_pre_edge in_ready: got %b expected 0", in_ready);
    end
    tick();
    got = {out_valid, in_ready, out_opcode, out_dest, out_ops};
    exp = {1'b0, 1'b1, 74'd0};
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL async_release_edge: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_params();
    out_ready3  = 1'b1;
    in_valid3   = 1'b1;
    in_opcode3  = 7'h05;
    in_dest3    = 3'd2;
    in_ops3     = 48'h3333_2222_1111;
    tick();
    in_valid3 = 1'b0;
    vecs++;
    if ({out_valid3, out_opcode3, out_dest3, out_ops3} !== {1'b1, 7'h05, 3'd2, 48'h3333_2222_1111}) begin
      errs++;
      $display("FAIL params_ops3: got %b %h %h %h expected 1 05 2 333322221111",
               out_valid3, out_opcode3, out_dest3, out_ops3);
    end
    tick();
    vecs++;
    if ({out_valid3, out_ops3} !== {1'b0, 48'h0}) begin
      errs++;
      $display("FAIL params_drain: got %b %h expected 0 000000000000", out_valid3, out_ops3);
    end
  endtask

  task automatic test_stall_cnt();
`ifdef PIPE_STALL_CNT_EN
    rst = 1'b1;
    tick();
    vecs++;
    if (stall_cnt !== 4'd0) begin
      errs++;
      $display("FAIL stall_reset: got %0d expected 0", stall_cnt);
    end
    rst = 1'b0;
    tick();
    out_ready = 1'b0;
    drive(1'b1, 7'h41, 3'd1, 64'h41);
    tick();
    drive(1'b0, '0, '0, '0);
    vecs++;
    if (stall_cnt !== 4'd0) begin
      errs++;
      $display("FAIL stall_load: got %0d expected 0", stall_cnt);
    end
    repeat (5) tick();
    vecs++;
    if (stall_cnt !== 4'd5) begin
      errs++;
      $display("FAIL stall_5: got %0d expected 5", stall_cnt);
    end
    repeat (15) tick();
    vecs++;
    if (stall_cnt !== 4'd15) begin
      errs++;
      $display("FAIL stall_saturate: got %0d expected 15", stall_cnt);
    end
    clr_sgn = 1'b1;
    tick();
    clr_sgn = 1'b0;
    vecs++;
    if ({out_valid, stall_cnt} !== {1'b0, 4'd15}) begin
      errs++;
      $display("FAIL stall_after_clr: got valid=%b cnt=%0d expected valid=0 cnt=15",
               out_valid, stall_cnt);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_params();
    test_stall_cnt();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
